// File: rtl/mux2_stream_arbiter_pkg.sv
// Shared state encodings and reset constants for the two-source packet arbiter.
package mux2_stream_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

   // Pointer names the last granted source; resetting to 1 lets source 0 win the first tie.
   localparam logic PTR_RESET = 1'b1;

   function automatic arb_state_t grant_state(input logic idx);
      return idx ? GRANT1 : GRANT0;
   endfunction

endpackage

// File: rtl/mux2_stream_arbiter_if.sv
// Bundle of the two source streams, the output stream and the grant status lines.
interface mux2_stream_arbiter_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] d0;
   logic             d0_valid;
   logic             d0_last;
   logic             d0_ready;
   logic [WIDTH-1:0] d1;
   logic             d1_valid;
   logic             d1_last;
   logic             d1_ready;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             out_last;
   logic             out_ready;
   logic             sel;
   logic             busy;

   // Environment side: drives both sources and the sink ready.
   modport master (
      output d0, d0_valid, d0_last, d1, d1_valid, d1_last, out_ready,
      input  d0_ready, d1_ready, out, out_valid, out_last, sel, busy
   );

   // Arbiter side.
   modport slave (
      input  d0, d0_valid, d0_last, d1, d1_valid, d1_last, out_ready,
      output d0_ready, d1_ready, out, out_valid, out_last, sel, busy
   );
endinterface

// File: rtl/mux2_stream_arbiter_rr_pick.sv
// Combinational round-robin choice between two requesters given the last-granted pointer.
module mux2_rr_pick (
   input  logic [1:0] req,
   input  logic       pointer,
   output logic       grant,
   output logic       grant_valid
);
   always_comb begin
      grant_valid = |req;
      grant       = 1'b0;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~pointer;
         default: grant = 1'b0;
      endcase
   end
endmodule

// File: rtl/mux2_stream_arbiter.sv
// Packet-locked round-robin arbiter feeding a registered valid/ready output stage.
module mux2_stream_arbiter
   import mux2_stream_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   mux2_stream_arbiter_if.slave   bus
);

   arb_state_t       state_reg, state_next;
   logic             ptr_reg, ptr_next;
   logic             sel_reg, sel_next;
   logic [WIDTH-1:0] out_reg;
   logic             out_valid_reg;
   logic             out_last_reg;

   logic             grant;
   logic             grant_valid;
   logic             slot_free;
   logic             ready0, ready1;
   logic             accept;
   logic [WIDTH-1:0] acc_data;
   logic             acc_last;

   mux2_rr_pick u_pick (
      .req         ({bus.d1_valid, bus.d0_valid}),
      .pointer     (ptr_reg),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Output slot can take a beat when empty or being drained this cycle.
   assign slot_free = !out_valid_reg || bus.out_ready;

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      sel_next   = sel_reg;
      ready0     = 1'b0;
      ready1     = 1'b0;
      accept     = 1'b0;
      acc_data   = '0;
      acc_last   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant_valid) begin
               state_next = grant_state(grant);
               ptr_next   = grant;
               sel_next   = grant;
            end
         end
         GRANT0: begin
            ready0 = slot_free;
            if (bus.d0_valid && slot_free) begin
               accept   = 1'b1;
               acc_data = bus.d0;
               acc_last = bus.d0_last;
               if (bus.d0_last) state_next = IDLE;
            end
         end
         GRANT1: begin
            ready1 = slot_free;
            if (bus.d1_valid && slot_free) begin
               accept   = 1'b1;
               acc_data = bus.d1;
               acc_last = bus.d1_last;
               if (bus.d1_last) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         ptr_reg   <= PTR_RESET;
         sel_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         sel_reg   <= sel_next;
      end
   end

   // out/out_last keep their last value after a drain; only out_valid falls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
      end else if (accept) begin
         out_reg       <= acc_data;
         out_valid_reg <= 1'b1;
         out_last_reg  <= acc_last;
      end else if (out_valid_reg && bus.out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign bus.d0_ready  = ready0;
   assign bus.d1_ready  = ready1;
   assign bus.out       = out_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_last  = out_last_reg;
   assign bus.sel       = sel_reg;
   assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Randomized scoreboard bench for mux2_stream_arbiter against a packet-level reference model.
module tb_mux2_stream_arbiter;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mux2_stream_arbiter_if #(.WIDTH(WIDTH)) bus ();

   mux2_stream_arbiter #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Beats are stored as {last, data}; source queues always hold whole packets.
   logic [WIDTH:0] src_q0[$];
   logic [WIDTH:0] src_q1[$];
   logic [WIDTH:0] exp_q[$];

   // Reference model: who owns the output, last granted source, output slot occupancy.
   bit m_busy  = 1'b0;
   bit m_owner = 1'b0;
   bit m_ptr   = 1'b1;
   bit m_sel   = 1'b0;
   bit m_ov    = 1'b0;

   int unsigned p_v0  = 0;
   int unsigned p_v1  = 0;
   int unsigned p_rdy = 100;
   int          acc_cnt0 = 0;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic load0(input logic [WIDTH-1:0] data, input bit last);
      src_q0.push_back({last, data});
   endtask

   task automatic load1(input logic [WIDTH-1:0] data, input bit last);
      src_q1.push_back({last, data});
   endtask

   task automatic load_rand(input int n);
      for (int p = 0; p < n; p++) begin
         int len0 = int'($urandom_range(4, 1));
         int len1 = int'($urandom_range(4, 1));
         for (int b = 0; b < len0; b++) load0(WIDTH'($urandom), b == len0 - 1);
         for (int b = 0; b < len1; b++) load1(WIDTH'($urandom), b == len1 - 1);
      end
   endtask

   task automatic push_packet(input bit src);
      if (!src) begin
         foreach (src_q0[i]) begin
            exp_q.push_back(src_q0[i]);
            if (src_q0[i][WIDTH]) break;
         end
      end else begin
         foreach (src_q1[i]) begin
            exp_q.push_back(src_q1[i]);
            if (src_q1[i][WIDTH]) break;
         end
      end
   endtask

   // One clock cycle: drive at negedge, check and advance the model 1 time unit later.
   task automatic cycle(input bit do_rst);
      bit v0, v1, rdy, acc0, acc1, busy_now, last0, last1, g;
      @(negedge clk);
      rst = do_rst;
      v0 = (src_q0.size() > 0) && ($urandom_range(99) < p_v0);
      v1 = (src_q1.size() > 0) && ($urandom_range(99) < p_v1);
      if (v0) {bus.d0_last, bus.d0} = src_q0[0];
      else    {bus.d0_last, bus.d0} = (WIDTH+1)'($urandom);
      if (v1) {bus.d1_last, bus.d1} = src_q1[0];
      else    {bus.d1_last, bus.d1} = (WIDTH+1)'($urandom);
      bus.d0_valid  = v0;
      bus.d1_valid  = v1;
      bus.out_ready = ($urandom_range(99) < p_rdy);
      #1;
      if (do_rst) begin
         src_q0.delete();
         src_q1.delete();
         exp_q.delete();
         m_busy = 1'b0;
         m_ptr  = 1'b1;
         m_sel  = 1'b0;
         m_ov   = 1'b0;
         return;
      end
      rdy = !m_ov || bus.out_ready;
      check("busy",      int'(bus.busy),      int'(m_busy));
      check("sel",       int'(bus.sel),       int'(m_sel));
      check("out_valid", int'(bus.out_valid), int'(m_ov));
      check("d0_ready",  int'(bus.d0_ready),  int'(m_busy && !m_owner && rdy));
      check("d1_ready",  int'(bus.d1_ready),  int'(m_busy && m_owner && rdy));
      acc0 = v0 && bus.d0_ready;
      acc1 = v1 && bus.d1_ready;
      busy_now = m_busy;
      if (acc0 || acc1) m_ov = 1'b1;
      else if (m_ov && bus.out_ready) m_ov = 1'b0;
      if (acc0) begin
         last0 = src_q0[0][WIDTH];
         void'(src_q0.pop_front());
         acc_cnt0++;
         if (last0 && m_busy && !m_owner) m_busy = 1'b0;
      end
      if (acc1) begin
         last1 = src_q1[0][WIDTH];
         void'(src_q1.pop_front());
         if (last1 && m_busy && m_owner) m_busy = 1'b0;
      end
      if (!busy_now && (v0 || v1)) begin
         g = (v0 && v1) ? !m_ptr : v1;
         m_busy  = 1'b1;
         m_owner = g;
         m_ptr   = g;
         m_sel   = g;
         push_packet(g);
      end
   endtask

   task automatic drain();
      int n = 0;
      p_v0 = 100; p_v1 = 100; p_rdy = 100;
      while ((exp_q.size() != 0 || src_q0.size() != 0 || src_q1.size() != 0 || m_busy || m_ov)
             && n < 500) begin
         cycle(1'b0);
         n++;
      end
      checks++;
      if (n >= 500) begin
         failures++;
         $display("FAIL drain_timeout: %0d beats still expected after %0d cycles", exp_q.size(), n);
      end
   endtask

   // Monitor: every output handshake pops the scoreboard.
   always begin
      logic [WIDTH:0] e;
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_beat: got unexpected beat %0h expected none", bus.out);
         end else begin
            e = exp_q.pop_front();
            $display("beat data=%02h last=%0d sel=%0d", bus.out, bus.out_last, bus.sel);
            check("out_data", int'(bus.out),      int'(e[WIDTH-1:0]));
            check("out_last", int'(bus.out_last), int'(e[WIDTH]));
         end
      end
   end

   initial begin
      int n;
      bus.d0 = '0; bus.d0_valid = 1'b0; bus.d0_last = 1'b0;
      bus.d1 = '0; bus.d1_valid = 1'b0; bus.d1_last = 1'b0;
      bus.out_ready = 1'b1;

      // Reset held 2 cycles, then 10 idle cycles.
      cycle(1'b1);
      cycle(1'b1);
      cycle(1'b0);
      check("reset_out",      int'(bus.out),      0);
      check("reset_out_last", int'(bus.out_last), 0);
      repeat (9) cycle(1'b0);

      // Single source streaming.
      load0(8'h11, 1'b0); load0(8'h22, 1'b0); load0(8'h33, 1'b1);
      p_v0 = 100; p_v1 = 0; p_rdy = 100;
      repeat (8) cycle(1'b0);

      // Tie from reset and round-robin alternation.
      cycle(1'b1);
      repeat (3) begin
         load0(8'hA0, 1'b0); load0(8'hA1, 1'b1);
         load1(8'hB0, 1'b0); load1(8'hB1, 1'b1);
      end
      p_v0 = 100; p_v1 = 100; p_rdy = 100;
      repeat (20) cycle(1'b0);
      drain();

      // Back-pressure heavy traffic.
      load_rand(6);
      p_v0 = 100; p_v1 = 100; p_rdy = 40;
      repeat (80) cycle(1'b0);
      drain();

      // Packet lock: source 0 stalls mid-packet while source 1 keeps requesting.
      load_rand(6);
      p_v0 = 40; p_v1 = 100; p_rdy = 80;
      repeat (100) cycle(1'b0);
      drain();

      // Reset after the 2nd beat of a 4-beat source 0 packet.
      cycle(1'b1);
      load0(8'hC0, 1'b0); load0(8'hC1, 1'b0); load0(8'hC2, 1'b0); load0(8'hC3, 1'b1);
      p_v0 = 100; p_v1 = 0; p_rdy = 100;
      acc_cnt0 = 0;
      n = 0;
      while (acc_cnt0 < 2 && n < 50) begin
         cycle(1'b0);
         n++;
      end
      check("mid_reset_reached", int'(acc_cnt0 >= 2), 1);
      cycle(1'b1);
      cycle(1'b0);
      check("post_reset_out_valid", int'(bus.out_valid), 0);
      check("post_reset_busy",      int'(bus.busy),      0);
      load0(8'hD0, 1'b1);
      load1(8'hE0, 1'b1);
      p_v0 = 100; p_v1 = 100;
      cycle(1'b0);
      cycle(1'b0);
      check("post_reset_first_grant", int'(bus.sel), 0);
      drain();

      // Fully random mix.
      for (int r = 0; r < 4; r++) begin
         load_rand(8);
         p_v0 = $urandom_range(100, 30);
         p_v1 = $urandom_range(100, 30);
         p_rdy = $urandom_range(100, 30);
         repeat (150) cycle(1'b0);
         drain();
      end

      repeat (3) cycle(1'b0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux2_stream_arbiter.md
Name: mux2_stream_arbiter

Overview:
- Two-requester packet arbiter that sequences a 2:1 select path. It owns the select line, grants one source at a time with round-robin fairness, and holds the grant for a whole packet.
- Forwards the granted source's beats through a registered valid/ready output stage.
- Sits upstream of any single-consumer sink that must be shared between two producers.

Parameters:
- WIDTH, 8, data width of each input and the output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- d0  in  WIDTH  source 0 data.
- d0_valid  in  1  source 0 beat valid.
- d0_last  in  1  source 0 final beat of packet.
- d0_ready  out  1  source 0 beat accepted when d0_valid && d0_ready.
- d1, d1_valid, d1_last, d1_ready: same as source 0, for source 1.
- out  out  WIDTH  registered selected data.
- out_valid  out  1  output beat valid.
- out_last  out  1  output final beat of packet.
- out_ready  in  1  sink accepts when out_valid && out_ready.
- sel  out  1  current grant: 0 = source 0, 1 = source 1; meaningful while busy.
- busy  out  1  a packet grant is held.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: out = 0, out_valid = 0, out_last = 0, d0_ready = 0, d1_ready = 0, sel = 0, busy = 0, state = IDLE, priority pointer = 1 (so source 0 wins the first tie).
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - d0_valid only -> GRANT0.
  - d1_valid only -> GRANT1.
  - Both valid -> grant the source opposite to the pointer.
  - Neither valid -> stay in IDLE.
  - No input is accepted in the IDLE cycle. There is one arbitration bubble per packet.
- On entering GRANTn: pointer <= n, sel <= n, busy <= 1.
- GRANTn ready: dn_ready = (!out_valid || out_ready). The other source's ready is 0. Ready does not depend on dn_valid.
- Accept: when dn_valid && dn_ready, register out <= dn, out_last <= dn_last, out_valid <= 1. Latency is 1 cycle from input accept to out_valid.
- Output drain: if out_valid && out_ready and no new accept that cycle, out_valid <= 0. out and out_last hold their values.
- Packet end: accepting a beat with dn_last = 1 -> next state IDLE, busy <= 0. sel keeps its value until the next grant.
- Requester drops valid mid-packet: the grant is held and the arbiter waits indefinitely. No timeout, no pre-emption.
- Single-beat packet (valid and last on the first beat) is legal. It takes GRANT for exactly one accept.
- Sustained throughput: 1 beat/cycle within a packet while out_ready = 1.
- Back-pressure: while out_valid && !out_ready, dn_ready = 0. out, out_last and out_valid hold stable.
- Source inputs that are not granted are ignored, including their last flags.
- Reset mid-packet: the packet is discarded, all outputs and state take reset values, and the pointer returns to 1. A partially sent packet is not resumed.
- Reset has priority over every other event in the same cycle.

Decomposition:
- Shared package/header: state encodings (IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2) and the reset pointer constant.
- One natural sub-module: mux2_rr_pick. It is combinational. Inputs: req[1:0] and pointer. Outputs: grant index and grant_valid. This leaves the FSM, output register and handshake in the top.

Test Plan:
- Idle/reset: hold rst for 2 cycles, then release with no valids -> out_valid = 0, busy = 0, both readies 0 for 10 cycles.
- Single source streaming: d0 sends 3-beat packet 0x11, 0x22, 0x33 (last on 0x33) with out_ready = 1 -> GRANT0 after 1 cycle. out shows 0x11, 0x22, 0x33 on consecutive cycles, out_last only with 0x33. busy drops the cycle after the last accept.
- Tie and round-robin: both sources valid from reset with 2-beat packets (d0: 0xA0, 0xA1; d1: 0xB0, 0xB1), both repeating -> order A0 A1 B0 B1 A0 A1 ...; sel toggles 0, 1, 0.
- Back-pressure: during a d1 packet, deassert out_ready for 3 cycles with out_valid = 1 -> d1_ready = 0, out stable for those cycles. Resume -> no beat lost or duplicated.
- Packet lock: d0 packet in flight, d0_valid drops for 4 cycles while d1_valid = 1 -> d1_ready stays 0 and sel = 0. d0 resumes and completes, then d1 is granted.
- Reset mid-packet: assert rst after the 2nd beat of a 4-beat d0 packet -> next cycle out_valid = 0, busy = 0, pointer reset. After release with both valid -> d0 is granted first.
